// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard controller:
//               MDU scoreboard state encoding and Execute-stage forward-select
//               codes.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // MDU scoreboard states: waiting for an op, counting latency, result held.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  // Execute-stage operand source select.
  localparam logic [1:0] FWD_RF = 2'b00;  // register file
  localparam logic [1:0] FWD_W  = 2'b01;  // Writeback result
  localparam logic [1:0] FWD_M  = 2'b10;  // Memory-stage ALU result

endpackage
`default_nettype wire

// File: rtl/mdu_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : mdu_scoreboard
// Description : Tracks a multi-cycle MUL/DIV op occupying the Execute stage.
//               Raises MduStall_o while the op is still computing and
//               MduDone_o once the result is valid, holding the result valid
//               until Execute is allowed to advance.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               MduE_i         - Execute holds a MUL/DIV instruction
//               StallE_i       - Execute stage is held this cycle
//               MduStall_o     - MDU still computing, hold Execute
//               MduDone_o      - MDU result valid this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_scoreboard
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = $clog2(MDU_LAT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic MduE_i,
  input  logic StallE_i,
  output logic MduStall_o,
  output logic MduDone_o
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(MDU_LAT - 1);

  mdu_state_t       state_q, state_d, state_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_w;

  always_comb begin
    // While reset is asserted the outputs reflect the idle state.
    state_w    = rst ? IDLE : state_q;
    state_d    = state_w;
    cnt_d      = cnt_q;
    MduStall_o = 1'b0;
    done_w     = 1'b0;
    case (state_w)
      IDLE: begin
        if (MduE_i) begin
          if (MDU_LAT > 1) begin
            MduStall_o = 1'b1;
            cnt_d      = CNT_W'(1);
            state_d    = BUSY;
          end else begin
            // Single-cycle op: result is ready on entry.
            done_w  = 1'b1;
            state_d = StallE_i ? DONE : IDLE;
          end
        end
      end
      BUSY: begin
        // Counter advances even under a memory stall.
        if (cnt_q < c_LAST) begin
          MduStall_o = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
        end else begin
          done_w  = 1'b1;
          state_d = StallE_i ? DONE : IDLE;
        end
      end
      DONE: begin
        // Keep the result valid until the op leaves Execute.
        done_w = 1'b1;
        if (!StallE_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MduDone_o = done_w & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard controller for the 5-stage RISC-V pipeline. Produces
//               Execute forwarding selects and all pipeline stall/flush
//               enables from load-use, JALR, branch, MDU and memory-wait
//               hazards.
// Ports       : clk, rst                  - clock, synchronous reset
//               Rs1D_i, Rs2D_i, JalrD_i   - Decode sources / JALR flag
//               Rs1E_i, Rs2E_i, RdE_i     - Execute registers
//               RegWriteE_i, LoadE_i, MduE_i, PCSrcE_i - Execute controls
//               RdM_i, RegWriteM_i, MemReadyM_i        - Memory stage
//               RdW_i, RegWriteW_i        - Writeback stage
//               Stall*_o, Flush*_o        - pipeline register controls
//               ForwardAE_o, ForwardBE_o  - Execute operand selects
//               MduDone_o                 - MDU result valid
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MDU_LAT    = 4,
  parameter int CNT_W      = $clog2(MDU_LAT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D_i,
  input  logic [REG_ADDR_W-1:0] Rs2D_i,
  input  logic                  JalrD_i,
  input  logic [REG_ADDR_W-1:0] Rs1E_i,
  input  logic [REG_ADDR_W-1:0] Rs2E_i,
  input  logic [REG_ADDR_W-1:0] RdE_i,
  input  logic                  RegWriteE_i,
  input  logic                  LoadE_i,
  input  logic                  MduE_i,
  input  logic                  PCSrcE_i,
  input  logic [REG_ADDR_W-1:0] RdM_i,
  input  logic                  RegWriteM_i,
  input  logic                  MemReadyM_i,
  input  logic [REG_ADDR_W-1:0] RdW_i,
  input  logic                  RegWriteW_i,
  output logic                  StallF_o,
  output logic                  StallD_o,
  output logic                  StallE_o,
  output logic                  StallM_o,
  output logic                  FlushD_o,
  output logic                  FlushE_o,
  output logic                  FlushM_o,
  output logic                  FlushW_o,
  output logic [1:0]            ForwardAE_o,
  output logic [1:0]            ForwardBE_o,
  output logic                  MduDone_o
);

  logic mem_stall_w, lw_stall_w, jalr_stall_w, mdu_stall_w, dec_stall_w;

  // Forwarding: newest producer (M) wins over W; x0 is never forwarded.
  always_comb begin
    ForwardAE_o = FWD_RF;
    if (RegWriteM_i && (Rs1E_i != '0) && (Rs1E_i == RdM_i)) begin
      ForwardAE_o = FWD_M;
    end else if (RegWriteW_i && (Rs1E_i != '0) && (Rs1E_i == RdW_i)) begin
      ForwardAE_o = FWD_W;
    end
    ForwardBE_o = FWD_RF;
    if (RegWriteM_i && (Rs2E_i != '0) && (Rs2E_i == RdM_i)) begin
      ForwardBE_o = FWD_M;
    end else if (RegWriteW_i && (Rs2E_i != '0) && (Rs2E_i == RdW_i)) begin
      ForwardBE_o = FWD_W;
    end
  end

  assign mem_stall_w  = ~MemReadyM_i;
  assign lw_stall_w   = LoadE_i & RegWriteE_i & (RdE_i != '0) &
                        ((Rs1D_i == RdE_i) | (Rs2D_i == RdE_i));
  // JALR needs its base register in Decode, so any in-flight producer stalls.
  assign jalr_stall_w = JalrD_i & (Rs1D_i != '0) &
                        (((Rs1D_i == RdE_i) & RegWriteE_i) |
                         ((Rs1D_i == RdM_i) & RegWriteM_i));
  // A taken branch discards the Decode instruction, so its hazards vanish.
  assign dec_stall_w  = (lw_stall_w | jalr_stall_w) & ~PCSrcE_i;

  mdu_scoreboard #(
    .MDU_LAT (MDU_LAT),
    .CNT_W   (CNT_W)
  ) u_mdu_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .MduE_i     (MduE_i),
    .StallE_i   (StallE_o),
    .MduStall_o (mdu_stall_w),
    .MduDone_o  (MduDone_o)
  );

  assign StallE_o = mem_stall_w | mdu_stall_w;
  assign StallM_o = mem_stall_w;
  assign FlushW_o = mem_stall_w;
  // Bubble into M only while M itself is free to advance.
  assign FlushM_o = mdu_stall_w & ~mem_stall_w;
  assign StallF_o = StallE_o | dec_stall_w;
  assign StallD_o = StallE_o | dec_stall_w;
  // Flushes wait until E advances, so a held branch keeps its redirect.
  assign FlushD_o = PCSrcE_i & ~StallE_o;
  assign FlushE_o = (lw_stall_w | jalr_stall_w | PCSrcE_i) & ~StallE_o;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Two instances (MDU_LAT=4
//               and MDU_LAT=1) share stimulus; an occupancy-based model checks
//               every output each cycle, and directed literals pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       JalrD, RegWriteE, LoadE, MduE, PCSrcE, RegWriteM, MemReadyM, RegWriteW;

  logic       StallF[2], StallD[2], StallE[2], StallM[2];
  logic       FlushD[2], FlushE[2], FlushM[2], FlushW[2];
  logic [1:0] FwdA[2], FwdB[2];
  logic       Done[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(5), .MDU_LAT(4)) dut4 (
    .clk(clk), .rst(rst), .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .JalrD_i(JalrD),
    .Rs1E_i(Rs1E), .Rs2E_i(Rs2E), .RdE_i(RdE), .RegWriteE_i(RegWriteE),
    .LoadE_i(LoadE), .MduE_i(MduE), .PCSrcE_i(PCSrcE), .RdM_i(RdM),
    .RegWriteM_i(RegWriteM), .MemReadyM_i(MemReadyM), .RdW_i(RdW),
    .RegWriteW_i(RegWriteW), .StallF_o(StallF[0]), .StallD_o(StallD[0]),
    .StallE_o(StallE[0]), .StallM_o(StallM[0]), .FlushD_o(FlushD[0]),
    .FlushE_o(FlushE[0]), .FlushM_o(FlushM[0]), .FlushW_o(FlushW[0]),
    .ForwardAE_o(FwdA[0]), .ForwardBE_o(FwdB[0]), .MduDone_o(Done[0]));

  hazard_ctrl #(.REG_ADDR_W(5), .MDU_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .JalrD_i(JalrD),
    .Rs1E_i(Rs1E), .Rs2E_i(Rs2E), .RdE_i(RdE), .RegWriteE_i(RegWriteE),
    .LoadE_i(LoadE), .MduE_i(MduE), .PCSrcE_i(PCSrcE), .RdM_i(RdM),
    .RegWriteM_i(RegWriteM), .MemReadyM_i(MemReadyM), .RdW_i(RdW),
    .RegWriteW_i(RegWriteW), .StallF_o(StallF[1]), .StallD_o(StallD[1]),
    .StallE_o(StallE[1]), .StallM_o(StallM[1]), .FlushD_o(FlushD[1]),
    .FlushE_o(FlushE[1]), .FlushM_o(FlushM[1]), .FlushW_o(FlushW[1]),
    .ForwardAE_o(FwdA[1]), .ForwardBE_o(FwdB[1]), .MduDone_o(Done[1]));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Highest-priority writer of a source register: 2 = M, 1 = W, 0 = none.
  function automatic int fwd_model(input logic [4:0] rs);
    if (rs != 0 && RegWriteM && rs == RdM) return 2;
    if (rs != 0 && RegWriteW && rs == RdW) return 1;
    return 0;
  endfunction

  // MDU occupancy model: age = cycles the op has already spent in Execute.
  int  lat[2] = '{4, 1};
  bit  act[2] = '{0, 0};
  int  age[2] = '{0, 0};

  always @(negedge clk) begin
    int a;
    bit mem, st, dn, se, lw, jr;
    mem = !MemReadyM;
    lw  = LoadE && RegWriteE && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
    jr  = JalrD && Rs1D != 0 && ((Rs1D == RdE && RegWriteE) || (Rs1D == RdM && RegWriteM));
    for (int k = 0; k < 2; k++) begin
      a  = (act[k] && !rst) ? age[k] : (MduE ? 0 : -1);
      st = (a >= 0) && (a < lat[k] - 1);
      dn = (a >= 0) && !st && !rst;
      se = mem || st;
      check($sformatf("StallF[%0d]", k), StallF[k], se || ((lw || jr) && !PCSrcE));
      check($sformatf("StallD[%0d]", k), StallD[k], se || ((lw || jr) && !PCSrcE));
      check($sformatf("StallE[%0d]", k), StallE[k], se);
      check($sformatf("StallM[%0d]", k), StallM[k], mem);
      check($sformatf("FlushW[%0d]", k), FlushW[k], mem);
      check($sformatf("FlushM[%0d]", k), FlushM[k], st && !mem);
      check($sformatf("FlushD[%0d]", k), FlushD[k], PCSrcE && !se);
      check($sformatf("FlushE[%0d]", k), FlushE[k], (lw || jr || PCSrcE) && !se);
      check($sformatf("FwdA[%0d]", k), FwdA[k], fwd_model(Rs1E));
      check($sformatf("FwdB[%0d]", k), FwdB[k], fwd_model(Rs2E));
      check($sformatf("Done[%0d]", k), Done[k], dn);
      if (rst || a < 0) act[k] = 0;
      else if (st) begin act[k] = 1; age[k] = a + 1; end
      else act[k] = se;  // result held while Execute is stalled
      if (!rst && a >= 0 && !st) age[k] = a;
    end
  end

  task automatic clr();
    Rs1D = 0; Rs2D = 0; JalrD = 0; Rs1E = 0; Rs2E = 0; RdE = 0;
    RegWriteE = 0; LoadE = 0; MduE = 0; PCSrcE = 0; RdM = 0; RegWriteM = 0;
    MemReadyM = 1; RdW = 0; RegWriteW = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1;
    clr();
    step(); step();
    #1;
    check("reset_all_zero",
          {StallF[0], StallD[0], StallE[0], StallM[0], FlushD[0], FlushE[0],
           FlushM[0], FlushW[0], FwdA[0], FwdB[0], Done[0]}, 0);
    step();
    rst = 0;

    // Forwarding priority
    Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; #1;
    check("fwd_M", FwdA[0], 2);
    RegWriteM = 0; #1;
    check("fwd_W", FwdA[0], 1);
    Rs1E = 0; #1;
    check("fwd_x0", FwdA[0], 0);
    step(); clr();

    // Load-use
    LoadE = 1; RegWriteE = 1; RdE = 3; Rs2D = 3; #1;
    check("lw_StallF", StallF[0], 1);
    check("lw_StallD", StallD[0], 1);
    check("lw_FlushE", FlushE[0], 1);
    check("lw_StallE", StallE[0], 0);
    step(); clr();

    // MDU op, no memory stall
    for (int c = 0; c < 5; c++) begin
      MduE = (c <= 3); #1;
      if (c <= 2) begin
        check("mdu_StallF", StallF[0], 1);
        check("mdu_FlushM", FlushM[0], 1);
      end
      if (c == 3) begin
        check("mdu_c3_StallE", StallE[0], 0);
        check("mdu_c3_Done", Done[0], 1);
      end
      if (c == 4) check("mdu_c4_Done", Done[0], 0);
      if (c == 0) begin
        check("lat1_Done", Done[1], 1);
        check("lat1_StallE", StallE[1], 0);
      end
      step();
    end
    clr();

    // MDU op with memory wait in cycles 2-5
    for (int c = 0; c < 8; c++) begin
      MduE = (c <= 6);
      MemReadyM = !(c >= 2 && c <= 5); #1;
      if (c == 2) begin
        check("mm_FlushM", FlushM[0], 0);
        check("mm_StallM", StallM[0], 1);
        check("mm_FlushW", FlushW[0], 1);
      end
      if (c == 3 || c == 5) check("mm_Done_held", Done[0], 1);
      if (c == 6) begin
        check("mm_c6_Done", Done[0], 1);
        check("mm_c6_StallE", StallE[0], 0);
      end
      if (c == 7) check("mm_c7_Done", Done[0], 0);
      step();
    end
    clr();

    // Branch priority
    JalrD = 1; Rs1D = 4; RdE = 4; RegWriteE = 1; PCSrcE = 1; #1;
    check("br_FlushD", FlushD[0], 1);
    check("br_FlushE", FlushE[0], 1);
    check("br_StallF", StallF[0], 0);
    check("br_StallD", StallD[0], 0);
    MemReadyM = 0; #1;
    check("brmem_FlushD", FlushD[0], 0);
    check("brmem_FlushE", FlushE[0], 0);
    step();
    MemReadyM = 1; #1;
    check("brmem_release", FlushD[0], 1);
    step(); clr();

    // Reset in the middle of an MDU op
    MduE = 1;
    step();
    check("rst_busy_StallE", StallE[0], 1);
    rst = 1;
    step();
    rst = 0; MduE = 0; #1;
    check("rst_Done", Done[0], 0);
    check("rst_StallE", StallE[0], 0);
    step();

    // Mixed vectors over a small register space
    for (int i = 0; i < 80; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3));
      RdW = 5'($urandom_range(0, 3));
      JalrD = 1'($urandom_range(0, 1)); RegWriteE = 1'($urandom_range(0, 1));
      LoadE = 1'($urandom_range(0, 1)); MduE = 1'($urandom_range(0, 1));
      PCSrcE = ($urandom_range(0, 3) == 0); RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1)); MemReadyM = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 19) == 0);
      step();
    end
    rst = 0; clr();
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
